// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                operation encodings, FSM state encoding and default width.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/md_fix_sign.sv
`default_nettype none
// ============================================================================
//  Module      : md_fix_sign
//  Description : Conditional two's-complement negation. Used to take operand
//                magnitudes and to restore the sign of products, quotients
//                and remainders.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_fix_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative radix-2 multiply/divide unit holding HI/LO.
//                MULT/MULTU use shift-add, DIV/DIVU use restoring division;
//                signed ops run on magnitudes and are sign-corrected in FIX.
//                Optional macro MD_HILO_WRITE_EN adds hi_we/lo_we/wdata
//                ports for direct HI/LO writes while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MD_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          r_state;
    md_state_t          w_next;
    logic               r_is_div;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dz;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;     // product, or {unused, dividend/quotient}
    logic [WIDTH-1:0]   r_rem;     // partial remainder (always < divisor)
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes: signed ops (op[0]==0) take |x|
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    md_fix_sign #(.W(WIDTH)) u_abs_a (.value(a), .negate(~op[0] & a[WIDTH-1]), .result(w_abs_a));
    md_fix_sign #(.W(WIDTH)) u_abs_b (.value(b), .negate(~op[0] & b[WIDTH-1]), .result(w_abs_b));

    // One shift-add multiply step: add multiplicand when LSB set, shift right
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mag_a : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // One restoring divide step: shift in next dividend bit, trial-subtract
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mag_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_mag_b;

    // Sign restoration applied during FIX
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_sdiff;
    assign w_sdiff = r_signed & (r_sign_a ^ r_sign_b);

    md_fix_sign #(.W(2*WIDTH)) u_fix_prod (.value(r_acc), .negate(w_sdiff & ~r_is_div), .result(w_prod_fix));
    md_fix_sign #(.W(WIDTH))   u_fix_quo  (.value(r_acc[WIDTH-1:0]), .negate(w_sdiff & r_is_div), .result(w_quo_fix));
    md_fix_sign #(.W(WIDTH))   u_fix_rem  (.value(r_rem), .negate(r_signed & r_is_div & r_sign_a), .result(w_rem_fix));

    // With a zero divisor every trial subtract succeeds, so the remainder
    // ends up as |a| and its sign fix reproduces the raw operand a; only the
    // quotient needs forcing to all ones.
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    assign w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_dz ? {WIDTH{1'b1}} : w_quo_fix) : w_prod_fix[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dz     <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
`ifdef MD_HILO_WRITE_EN
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
`endif
                    if (start) begin
                        r_is_div <= op[1];
                        r_signed <= ~op[0];
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_dz     <= op[1] & (b == '0);
                        r_mag_a  <= w_abs_a;
                        r_mag_b  <= w_abs_b;
                        r_rem    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_rem               <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_acc[WIDTH-1:0]    <= {r_acc[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                end
                ST_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done     = (r_state == ST_DONE);
    assign div_zero = done & r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Scoreboard bench for mul_div_unit: directed and random
//                operations checked against a 64-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import md_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MD_HILO_WRITE_EN
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
`endif

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
`ifdef MD_HILO_WRITE_EN
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp = '0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic from the instruction semantics
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e  = '0;
        case (o)
            MD_MULT: begin
                p = 64'(sx * sy);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (o == MD_DIV) begin
                    q = 64'(sx / sy);
                    r = 64'(sx % sy);
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end else begin
                    e.hi = x % y;
                    e.lo = x / y;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: compare each completed result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (div_zero && !done) begin
            n_vec++;
            n_err++;
            $display("FAIL div_zero_without_done: got 1, expected 0");
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("div_zero_flag", {31'b0, div_zero}, {31'b0, e.dz});
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && (busy || done); i++) @(negedge clk);
        check("idle_wait", {30'b0, busy, done}, 32'd0);
    endtask

    // Issue one operation. restart_at: cycle to pulse a stray start;
    // rst_at: cycle at which reset aborts the operation (0 = never).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int restart_at, input int rst_at);
        int lat;
        int busy_bad;
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back(model(o, x, y));
        last_exp = model(o, x, y);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat      = 0;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == restart_at) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_done", {31'b0, done}, 32'd0);
                check("abort_hi", hi, 32'd0);
                check("abort_lo", lo, 32'd0);
                void'(sb_q.pop_back());
                last_exp = '0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) begin
                lat = k;
                if (busy) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        check("latency", 32'(lat), 32'd34);
        check("busy_profile", 32'(busy_bad), 32'd0);
        if (restart_at >= 34) begin
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clk);
        check("hold_hi", hi, last_exp.hi);
        check("hold_lo", lo, last_exp.lo);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;

        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_div_zero", {31'b0, div_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        check_hold();
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(MD_DIVU,  32'd100,       32'd7,         0, 0);
        run_op(MD_DIVU,  32'h1234_5678, 32'h0000_0000, 0, 0);
        run_op(MD_DIV,   32'h8765_4321, 32'h0000_0000, 0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(MD_MULTU, 32'd3,         32'd5,        10, 0);
        check_hold();
        run_op(MD_DIVU,  32'hDEAD_BEEF, 32'd13,        0, 15);
        check_hold();
        run_op(MD_DIVU,  32'd100,       32'd7,         0, 0);
        run_op(MD_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        check_hold();

`ifdef MD_HILO_WRITE_EN
        wait_idle();
        hi_we = 1'b1;
        wdata = 32'hA5A5_1234;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h0F0F_5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("write_hi", hi, 32'hA5A5_1234);
        check("write_lo", lo, 32'h0F0F_5678);
        last_exp.hi = 32'hA5A5_1234;
        last_exp.lo = 32'h0F0F_5678;
        check_hold();
`endif

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 15));
                default: begin
                end
            endcase
            run_op(o, x, y, 0, 0);
        end
        check_hold();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
